// File: rtl/cw_bank_select.sv
`default_nettype none
// ============================================================================
// Module   : cw_bank_select
// Function : Double-buffered codebook with per-beam even/odd codeword readout,
//            symbol-phase or explicit-index selection, glitch-free bank swap.
// Revision : 1.0 - initial release
// ============================================================================
module cw_bank_select #(
  parameter  int ANTS  = 32,
  parameter  int BEAM  = 16,
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_en,
  input  logic [IDXW-1:0]             i_wr_addr,
  input  logic [WIDTH*ANTS-1:0]       i_wr_even,
  input  logic [WIDTH*ANTS-1:0]       i_wr_odd,
  input  logic                        i_wr_last,
  output logic                        o_wr_ready,
  output logic                        o_tbl_valid,
  input  logic                        i_mode,
  input  logic                        i_rbg_load,
  input  logic [BEAM*8-1:0]           i_beam_idx,
  input  logic [7:0]                  i_symb_idx,
  input  logic                        i_symb_clr,
  output logic [BEAM*WIDTH*ANTS-1:0]  o_cw_even,
  output logic [BEAM*WIDTH*ANTS-1:0]  o_cw_odd,
  output logic [BEAM-1:0]             o_idx_err,
  output logic                        o_tvalid
);

  localparam int PHASES = DEPTH / BEAM;
  localparam int c_ew = WIDTH * ANTS;
  localparam logic [IDXW:0] c_depth_w = (IDXW+1)'(DEPTH);
  localparam logic [8:0]    c_depth_9 = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t r_state, w_state_next;
  logic   r_act_bank, w_act_bank_next;
  logic   w_wr_ready, w_tbl_valid, w_wr_accept, w_commit, w_req;

  logic [c_ew-1:0] r_mem_even [0:1][0:DEPTH-1];
  logic [c_ew-1:0] r_mem_odd  [0:1][0:DEPTH-1];

  logic            r_s1_valid;
  logic            r_s1_bank;
  logic [7:0]      r_s1_idx [0:BEAM-1];
  logic [7:0]      w_s1_idx [0:BEAM-1];
  logic [15:0]     w_phase;

  logic [BEAM*c_ew-1:0] r_cw_even, r_cw_odd;
  logic [BEAM-1:0]      r_idx_err;
  logic                 r_tvalid;

  assign w_wr_ready  = (r_state != ST_PENDING);
  assign w_tbl_valid = (r_state != ST_EMPTY);
  assign w_wr_accept = i_wr_en && w_wr_ready && !i_reset &&
                       ({1'b0, i_wr_addr} < c_depth_w);
  assign w_commit    = i_wr_last && w_wr_ready;
  assign w_req       = i_rbg_load && w_tbl_valid;

  // Table state: the first commit goes live at once, later ones wait for a symbol boundary
  always_comb begin
    w_state_next    = r_state;
    w_act_bank_next = r_act_bank;
    case (r_state)
      ST_EMPTY: begin
        if (w_commit) begin
          w_state_next    = ST_ACTIVE;
          w_act_bank_next = ~r_act_bank;
        end
      end
      ST_ACTIVE: begin
        if (w_commit) w_state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (i_symb_clr) begin
          w_state_next    = ST_ACTIVE;
          w_act_bank_next = ~r_act_bank;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_EMPTY;
      r_act_bank <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_act_bank <= w_act_bank_next;
    end
  end

  // Storage is never cleared; writes land only in the shadow bank
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem_even[~r_act_bank][i_wr_addr] <= i_wr_even;
      r_mem_odd[~r_act_bank][i_wr_addr]  <= i_wr_odd;
    end
  end

  always_comb begin
    w_phase = 16'({8'd0, i_symb_idx} % 16'(PHASES));
    for (int b = 0; b < BEAM; b++) begin
      if (i_mode) w_s1_idx[b] = i_beam_idx[b*8 +: 8];
      else        w_s1_idx[b] = 8'(16'(b) + 16'(BEAM) * w_phase);
    end
  end

  // Stage 1 latches the post-swap bank so a same-cycle swap is seen by this request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_req;
      if (w_req) begin
        r_s1_bank <= w_act_bank_next;
        r_s1_idx  <= w_s1_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tvalid  <= 1'b0;
      r_cw_even <= '0;
      r_cw_odd  <= '0;
      r_idx_err <= '0;
    end else begin
      r_tvalid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int b = 0; b < BEAM; b++) begin
          if ({1'b0, r_s1_idx[b]} < c_depth_9) begin
            r_cw_even[b*c_ew +: c_ew] <= r_mem_even[r_s1_bank][r_s1_idx[b][IDXW-1:0]];
            r_cw_odd[b*c_ew +: c_ew]  <= r_mem_odd[r_s1_bank][r_s1_idx[b][IDXW-1:0]];
            r_idx_err[b]              <= 1'b0;
          end else begin
            r_cw_even[b*c_ew +: c_ew] <= '0;
            r_cw_odd[b*c_ew +: c_ew]  <= '0;
            r_idx_err[b]              <= 1'b1;
          end
        end
      end
    end
  end

  assign o_wr_ready  = w_wr_ready;
  assign o_tbl_valid = w_tbl_valid;
  assign o_cw_even   = r_cw_even;
  assign o_cw_odd    = r_cw_odd;
  assign o_idx_err   = r_idx_err;
  assign o_tvalid    = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_cw_bank_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_cw_bank_select
// Function : Randomised self-checking bench for cw_bank_select against a
//            table-level reference model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cw_bank_select;
  localparam int ANTS   = 32;
  localparam int BEAM   = 16;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 64;
  localparam int IDXW   = $clog2(DEPTH);
  localparam int PHASES = DEPTH / BEAM;
  localparam int EW     = WIDTH * ANTS;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_wr_en = 1'b0;
  logic [IDXW-1:0]      i_wr_addr = '0;
  logic [EW-1:0]        i_wr_even = '0;
  logic [EW-1:0]        i_wr_odd = '0;
  logic                 i_wr_last = 1'b0;
  logic                 o_wr_ready;
  logic                 o_tbl_valid;
  logic                 i_mode = 1'b0;
  logic                 i_rbg_load = 1'b0;
  logic [BEAM*8-1:0]    i_beam_idx = '0;
  logic [7:0]           i_symb_idx = '0;
  logic                 i_symb_clr = 1'b0;
  logic [BEAM*EW-1:0]   o_cw_even;
  logic [BEAM*EW-1:0]   o_cw_odd;
  logic [BEAM-1:0]      o_idx_err;
  logic                 o_tvalid;

  always #5 i_clk = ~i_clk;

  cw_bank_select #(.ANTS(ANTS), .BEAM(BEAM), .WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_even(i_wr_even), .i_wr_odd(i_wr_odd),
    .i_wr_last(i_wr_last), .o_wr_ready(o_wr_ready), .o_tbl_valid(o_tbl_valid),
    .i_mode(i_mode), .i_rbg_load(i_rbg_load), .i_beam_idx(i_beam_idx),
    .i_symb_idx(i_symb_idx), .i_symb_clr(i_symb_clr),
    .o_cw_even(o_cw_even), .o_cw_odd(o_cw_odd), .o_idx_err(o_idx_err), .o_tvalid(o_tvalid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_wide(input string name, input logic [BEAM*EW-1:0] act,
                            input logic [BEAM*EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int w = 0; w < BEAM*EW/32; w++) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL %s word %0d: got %h expected %h at %0t",
                   name, w, act[w*32 +: 32], exp[w*32 +: 32], $time);
          break;
        end
      end
    end
  endtask

  // Reference model: two banks, a live pointer, and a two-deep request pipe
  logic [EW-1:0]      m_bank_even [2][DEPTH];
  logic [EW-1:0]      m_bank_odd  [2][DEPTH];
  bit                 m_init = 0, m_act, m_have, m_pend, m_rdy, m_swap, m_sel;
  bit                 m_p1_valid, m_tvalid;
  logic [BEAM*EW-1:0] m_p1_even, m_p1_odd, m_even, m_odd;
  logic [BEAM-1:0]    m_p1_err, m_err;
  int                 m_idx;

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_init = 1; m_act = 0; m_have = 0; m_pend = 0;
      m_p1_valid = 0; m_tvalid = 0;
      m_even = '0; m_odd = '0; m_err = '0;
    end else if (m_init) begin
      m_rdy    = !m_pend;
      m_tvalid = m_p1_valid;
      if (m_p1_valid) begin
        m_even = m_p1_even; m_odd = m_p1_odd; m_err = m_p1_err;
      end
      m_swap     = m_pend && i_symb_clr;
      m_sel      = m_swap ? !m_act : m_act;
      m_p1_valid = i_rbg_load && m_have;
      if (m_p1_valid) begin
        for (int b = 0; b < BEAM; b++) begin
          if (i_mode) m_idx = int'(i_beam_idx[b*8 +: 8]);
          else        m_idx = b + BEAM * (int'(i_symb_idx) % PHASES);
          if (m_idx >= DEPTH) begin
            m_p1_even[b*EW +: EW] = '0;
            m_p1_odd[b*EW +: EW]  = '0;
            m_p1_err[b]           = 1'b1;
          end else begin
            m_p1_even[b*EW +: EW] = m_bank_even[m_sel][m_idx];
            m_p1_odd[b*EW +: EW]  = m_bank_odd[m_sel][m_idx];
            m_p1_err[b]           = 1'b0;
          end
        end
      end
      if (i_wr_en && m_rdy) begin
        m_bank_even[!m_act][i_wr_addr] = i_wr_even;
        m_bank_odd[!m_act][i_wr_addr]  = i_wr_odd;
      end
      if (i_wr_last && m_rdy) begin
        if (!m_have) begin m_have = 1; m_act = !m_act; end
        else m_pend = 1;
      end else if (m_swap) begin
        m_act = !m_act; m_pend = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (m_init) begin
      check("tvalid",    64'(o_tvalid),    64'(m_tvalid));
      check("tbl_valid", 64'(o_tbl_valid), 64'(m_have));
      check("wr_ready",  64'(o_wr_ready),  64'(!m_pend));
      check("idx_err",   64'(o_idx_err),   64'(m_err));
      check_wide("cw_even", o_cw_even, m_even);
      check_wide("cw_odd",  o_cw_odd,  m_odd);
    end
  end

  function automatic logic [EW-1:0] rand_word();
    logic [EW-1:0] w;
    for (int i = 0; i < EW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic clear_ctl();
    i_wr_en = 0; i_wr_last = 0; i_rbg_load = 0; i_symb_clr = 0;
  endtask

  task automatic write_all(input int offset);
    for (int a = 0; a < DEPTH; a++) begin
      i_wr_en = 1; i_wr_addr = IDXW'(a);
      i_wr_even = EW'(a + offset); i_wr_odd = ~EW'(a + offset);
      i_wr_last = (a == DEPTH-1);
      @(negedge i_clk);
    end
    clear_ctl();
  endtask

  // Issues one request; returns at the negedge where its result is visible
  task automatic request(input logic mode, input logic [7:0] symb, input logic clr);
    i_rbg_load = 1; i_mode = mode; i_symb_idx = symb; i_symb_clr = clr;
    @(negedge i_clk);
    clear_ctl();
    @(negedge i_clk);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    i_reset = 0;
    check("rst_wr_ready", 64'(o_wr_ready), 64'd1);
    check("rst_tbl_valid", 64'(o_tbl_valid), 64'd0);
    check("rst_cw_even", o_cw_even[63:0], 64'd0);

    request(1'b0, 8'd0, 1'b0);
    check("nocommit_tvalid", 64'(o_tvalid), 64'd0);
    check("nocommit_cw", o_cw_even[5*EW +: 64], 64'd0);

    write_all(0);
    check("commit_tbl_valid", 64'(o_tbl_valid), 64'd1);

    request(1'b0, 8'd2, 1'b0);
    check("m0_tvalid", 64'(o_tvalid), 64'd1);
    check("m0_b5_even", o_cw_even[5*EW +: 64], 64'd37);
    check("m0_b5_odd", o_cw_odd[5*EW +: 64], 64'hFFFF_FFFF_FFFF_FFDA);
    @(negedge i_clk);
    check("m0_tvalid_drop", 64'(o_tvalid), 64'd0);

    for (int b = 0; b < BEAM; b++) i_beam_idx[b*8 +: 8] = 8'($urandom_range(0, DEPTH-1));
    i_beam_idx[3*8 +: 8] = 8'd10;
    i_beam_idx[7*8 +: 8] = 8'd200;
    request(1'b1, 8'd0, 1'b0);
    check("m1_b3_even", o_cw_even[3*EW +: 64], 64'd10);
    check("m1_b7_even", o_cw_even[7*EW +: 64], 64'd0);
    check("m1_b7_odd", o_cw_odd[7*EW +: 64], 64'd0);
    check("m1_idx_err", 64'(o_idx_err), 64'h0080);

    write_all(100);
    check("pend_wr_ready", 64'(o_wr_ready), 64'd0);
    request(1'b0, 8'd2, 1'b0);
    check("pend_old_data", o_cw_even[5*EW +: 64], 64'd37);
    i_wr_en = 1; i_wr_addr = IDXW'(5); i_wr_even = EW'(999); i_wr_odd = EW'(999);
    @(negedge i_clk);
    clear_ctl();
    request(1'b0, 8'd0, 1'b1);
    check("swap_new_data", o_cw_even[5*EW +: 64], 64'd105);
    check("swap_wr_ready", 64'(o_wr_ready), 64'd1);
    i_wr_last = 1; @(negedge i_clk); clear_ctl();
    i_symb_clr = 1; @(negedge i_clk); clear_ctl();
    i_wr_last = 1; @(negedge i_clk); clear_ctl();
    i_symb_clr = 1; @(negedge i_clk); clear_ctl();
    request(1'b0, 8'd0, 1'b0);
    check("dropped_write", o_cw_even[5*EW +: 64], 64'd105);

    i_rbg_load = 1; i_mode = 0; i_symb_idx = 8'd1;
    @(negedge i_clk);
    clear_ctl(); i_reset = 1;
    @(negedge i_clk);
    check("abort_tvalid", 64'(o_tvalid), 64'd0);
    check("abort_tbl_valid", 64'(o_tbl_valid), 64'd0);
    i_reset = 0;
    @(negedge i_clk);

    write_all(500);
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin i_rbg_load = 1; i_mode = 0; i_symb_idx = 8'(k); end
      else clear_ctl();
      @(negedge i_clk);
      if (k >= 1 && k <= 16) begin
        check("burst_tvalid", 64'(o_tvalid), 64'd1);
        check("burst_b0_even", o_cw_even[63:0], 64'(500 + BEAM * ((k-1) % PHASES)));
      end else if (k == 17) begin
        check("burst_end", 64'(o_tvalid), 64'd0);
      end
    end

    for (int c = 0; c < 2000; c++) begin
      i_reset    = ($urandom_range(0, 999) < 3);
      i_wr_en    = ($urandom_range(0, 99) < 30);
      i_wr_addr  = IDXW'($urandom_range(0, DEPTH-1));
      i_wr_even  = rand_word();
      i_wr_odd   = rand_word();
      i_wr_last  = ($urandom_range(0, 99) < 4);
      i_symb_clr = ($urandom_range(0, 99) < 8);
      i_rbg_load = ($urandom_range(0, 99) < 50);
      i_mode     = 1'($urandom_range(0, 1));
      i_symb_idx = 8'($urandom);
      for (int b = 0; b < BEAM; b++)
        i_beam_idx[b*8 +: 8] = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, DEPTH-1))
                                                           : 8'($urandom);
      @(negedge i_clk);
    end
    clear_ctl(); i_reset = 0;
    repeat (3) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cw_bank_select.md
Name: cw_bank_select

Overview:
- Parametrised successor to the ROM-fed per-beam codeword selector for PUSCH dimension reduction.
- Holds a double-buffered, runtime-writable codebook of DEPTH even/odd codeword pairs. Each entry is ANTS×WIDTH bits.
- On each RBG load, delivers one even/odd codeword pair per beam to the beamforming multipliers.
- Supports symbol-phase (round-robin) selection and explicit index selection. The shadow bank is swapped in atomically on a symbol boundary, so the table can be refreshed with no output glitches.

Parameters:
- ANTS, 32, antennas per codeword
- BEAM, 16, beams output in parallel
- WIDTH, 32, bits per antenna weight (complex I/Q packed)
- DEPTH, 64, codewords per bank; must be a multiple of BEAM and ≤ 256
- Derived, local: IDXW = clog2(DEPTH); PHASES = DEPTH/BEAM

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_wr_en  in  1  write codeword pair to shadow bank
- i_wr_addr  in  IDXW  shadow entry address
- i_wr_even  in  WIDTH*ANTS  even codeword data
- i_wr_odd  in  WIDTH*ANTS  odd codeword data
- i_wr_last  in  1  commit shadow bank (qualified by o_wr_ready)
- o_wr_ready  out  1  shadow bank accepting writes/commit
- o_tbl_valid  out  1  an active table exists
- i_mode  in  1  0 = symbol-phase select, 1 = index select
- i_rbg_load  in  1  selection request
- i_beam_idx  in  BEAM*8  per-beam codeword index (mode 1)
- i_symb_idx  in  8  current symbol index
- i_symb_clr  in  1  symbol boundary strobe; bank swap point
- o_cw_even  out  BEAM*WIDTH*ANTS  per-beam even codeword
- o_cw_odd  out  BEAM*WIDTH*ANTS  per-beam odd codeword
- o_idx_err  out  BEAM  per-beam index ≥ DEPTH on last request
- o_tvalid  out  1  one-cycle strobe: outputs updated

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk.
  - Reset drives state to EMPTY and act_bank to 0.
  - o_cw_even, o_cw_odd, o_idx_err and o_tvalid go to 0; o_tbl_valid goes to 0; o_wr_ready goes to 1.
  - Bank RAM contents are not cleared.
  - Reset mid-load or mid-request aborts the operation; no o_tvalid follows.
- Banks: two banks of DEPTH entries.
  - Writes always target the shadow bank (!act_bank).
  - Reads always use the bank latched at request stage 1.
- Table FSM:
  - EMPTY: ready = 1. An accepted i_wr_last swaps banks immediately and moves to ACTIVE.
  - ACTIVE: ready = 1, tbl_valid = 1. An accepted i_wr_last moves to PENDING.
  - PENDING: ready = 0, tbl_valid = 1. Writes and commits are ignored. On i_symb_clr, act_bank toggles and the FSM moves to ACTIVE.
  - i_wr_en and i_wr_last in the same cycle: the entry is written, then the commit applies. The committed bank includes that entry.
  - i_symb_clr in ACTIVE or EMPTY: no effect on the bank.
- Request pipeline (i_rbg_load with o_tbl_valid = 1; ignored otherwise):
  - Stage 1 (cycle +1): latch per-beam index and the bank pointer.
    - Mode 0: idx[i] = i + BEAM*(i_symb_idx mod PHASES).
    - Mode 1: idx[i] = i_beam_idx[i].
    - The bank pointer is the post-swap value if i_symb_clr swaps in the same cycle.
  - Stage 2 (cycle +2): register o_cw_even[i], o_cw_odd[i] and o_idx_err[i]; pulse o_tvalid for 1 cycle.
    - Index in range: output the bank entry.
    - Index ≥ DEPTH: output all-zero codewords and set err[i] = 1.
  - Back-to-back loads are fully pipelined: throughput 1 per cycle.
  - Outputs hold their values between strobes.
- Write/read collision: a write to the shadow bank never affects the active bank. A swap during an in-flight request does not change that request's data.
- Mode 0 wrap: the phase wraps modulo PHASES. With the defaults, symbol 4 reads the same entries as symbol 0.

Test Plan:
- Reset, load entries 0..63 with even = addr, odd = ~addr, commit → o_tbl_valid = 1 on next cycle; rbg_load, mode 0, symb_idx = 2 → 2 cycles later beam 5 even = 37, odd = ~37, o_tvalid for 1 cycle.
- Mode 1, beam_idx[3] = 10, beam_idx[7] = 200 → beam 3 even = 10; beam 7 even/odd = 0 and o_idx_err = 0x0080.
- While ACTIVE, rewrite the shadow bank with even = addr+100 and commit → o_wr_ready = 0. Requests still return the old values until i_symb_clr; the first request after it returns addr+100.
- i_symb_clr and rbg_load in the same cycle while PENDING → the request returns new-bank data. A write attempted during PENDING is dropped; verify the entry is unchanged after the next commit.
- rbg_load before any commit → no o_tvalid and outputs stay 0. Assert i_reset one cycle after an rbg_load → no o_tvalid, FSM returns to EMPTY.
- 16 consecutive rbg_load cycles, mode 0, symb_idx = 0..15 → 16 consecutive o_tvalid pulses; phase wraps every 4 symbols.
